// File: rtl/gpr_select_file.sv
// Bus consumer: instruction register, 16 GPRs and the field-select/encode
// logic that turns IR register fields into one-hot Rin/Rout enables.
module gpr_select_file #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int C_W    = 19
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        BusMuxOut,
    input  logic                     IRin,
    input  logic                     Gra,
    input  logic                     Grb,
    input  logic                     Grc,
    input  logic                     Rin,
    input  logic                     Rout,
    input  logic                     BAout,
    output logic [DATA_W-1:0]        IR,
    output logic [NREG*DATA_W-1:0]   R_flat,
    output logic [NREG-1:0]          R_out_sel,
    output logic [NREG-1:0]          R_in_sel,
    output logic [DATA_W-1:0]        C_sign_extended,
    output logic                     sel_error
);

    localparam int IDX_W = $clog2(NREG);

    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_sel_error;

    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_multi;
    logic [NREG-1:0]   w_dec;
    logic              w_wr;
    logic              w_ba_zero;

    // Priority Gra > Grb > Grc; a multi-select still decodes, but is flagged.
    always_comb begin
        w_idx = '0;
        if (Gra) begin
            w_idx = r_ir[26 -: IDX_W];
        end else if (Grb) begin
            w_idx = r_ir[22 -: IDX_W];
        end else if (Grc) begin
            w_idx = r_ir[18 -: IDX_W];
        end
    end

    assign w_any   = Gra | Grb | Grc;
    assign w_multi = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    assign w_dec   = {{(NREG-1){1'b0}}, 1'b1} << w_idx;
    assign w_wr    = Rin & w_any & ~clear;

    assign R_in_sel  = w_wr ? w_dec : '0;
    assign R_out_sel = ((Rout | BAout) & w_any & ~clear) ? w_dec : '0;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_ir <= '0;
        end else if (IRin) begin
            r_ir <= BusMuxOut;
        end
    end

    // Decode uses the pre-edge IR, so IRin+Rin writes at the old index.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[w_idx] <= BusMuxOut;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_sel_error <= 1'b0;
        end else if (w_multi) begin
            r_sel_error <= 1'b1;
        end
    end

    assign w_ba_zero = BAout & w_any & (w_idx == '0);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            R_flat[i*DATA_W +: DATA_W] = r_regs[i];
        end
        if (w_ba_zero) begin
            R_flat[0 +: DATA_W] = '0;
        end
    end

    assign IR              = r_ir;
    assign sel_error       = r_sel_error;
    assign C_sign_extended = {{(DATA_W-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};

endmodule

// File: tb/tb_gpr_select_file.sv
// Scoreboard bench for gpr_select_file: a reference model pushes expected
// values into a queue, and DUT observations pop and compare against them.
module tb_gpr_select_file;

    logic         clock = 1'b0;
    logic         clear;
    logic [31:0]  BusMuxOut;
    logic         IRin, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [31:0]  IR;
    logic [511:0] R_flat;
    logic [15:0]  R_out_sel;
    logic [15:0]  R_in_sel;
    logic [31:0]  C_sign_extended;
    logic         sel_error;

    gpr_select_file dut (
        .clock(clock),
        .clear(clear),
        .BusMuxOut(BusMuxOut),
        .IRin(IRin),
        .Gra(Gra),
        .Grb(Grb),
        .Grc(Grc),
        .Rin(Rin),
        .Rout(Rout),
        .BAout(BAout),
        .IR(IR),
        .R_flat(R_flat),
        .R_out_sel(R_out_sel),
        .R_in_sel(R_in_sel),
        .C_sign_extended(C_sign_extended),
        .sel_error(sel_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t        sbq [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_ir;
    logic [31:0] m_r [16];
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", got, ~got);
        end else begin
            e = sbq.pop_front();
            check(e.tag, got, e.v);
        end
    endtask

    function automatic logic m_any();
        return Gra | Grb | Grc;
    endfunction

    function automatic logic [3:0] m_idx();
        if (Gra) return m_ir[26:23];
        if (Grb) return m_ir[22:19];
        return m_ir[18:15];
    endfunction

    function automatic logic [31:0] m_sel(input logic en);
        logic [31:0] one;
        one = 32'd1;
        if (en && m_any() && !clear) return one << m_idx();
        return 32'd0;
    endfunction

    task automatic push_state(input string t);
        logic [31:0] v;
        sb_push({t, "_ir"}, m_ir);
        sb_push({t, "_c"}, {{13{m_ir[18]}}, m_ir[18:0]});
        sb_push({t, "_err"}, {31'd0, m_err});
        sb_push({t, "_insel"}, m_sel(Rin));
        sb_push({t, "_outsel"}, m_sel(Rout | BAout));
        for (int i = 0; i < 16; i++) begin
            v = m_r[i];
            if (i == 0 && BAout && m_any() && m_idx() == 4'd0) v = 32'd0;
            sb_push($sformatf("%s_r%0d", t, i), v);
        end
    endtask

    task automatic pop_state();
        sb_pop(IR);
        sb_pop(C_sign_extended);
        sb_pop({31'd0, sel_error});
        sb_pop({16'd0, R_in_sel});
        sb_pop({16'd0, R_out_sel});
        for (int i = 0; i < 16; i++) sb_pop(R_flat[32*i +: 32]);
    endtask

    task automatic model_clear();
        m_ir  = 32'd0;
        m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    endtask

    // Model the edge with pre-edge IR, push expectations, then take the edge.
    task automatic step(input string t);
        if (Rin && m_any()) m_r[m_idx()] = BusMuxOut;
        if ((Gra & Grb) | (Gra & Grc) | (Grb & Grc)) m_err = 1'b1;
        if (IRin) m_ir = BusMuxOut;
        push_state(t);
        @(posedge clock);
        #1;
        pop_state();
    endtask

    task automatic settle(input string t);
        #1;
        push_state(t);
        pop_state();
    endtask

    task automatic idle();
        {IRin, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    endtask

    task automatic pulse_clear(input string t);
        #1;
        clear = 1'b1;
        model_clear();
        settle(t);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        BusMuxOut = 32'd0;
        clear     = 1'b1;
        model_clear();
        #2;
        settle("rst0");
        clear = 1'b0;

        BusMuxOut = 32'h0A9A_0000;
        IRin = 1'b1;
        step("irld");
        IRin = 1'b0;
        sb_push("ir_const", 32'h0A9A_0000);
        sb_pop(IR);

        Gra = 1'b1; Rout = 1'b1;
        settle("ra_out");
        sb_push("ra_outsel", 32'h20);
        sb_pop({16'd0, R_out_sel});
        idle();
        Grb = 1'b1; Rin = 1'b1;
        settle("rb_in");
        sb_push("rb_insel", 32'h8);
        sb_pop({16'd0, R_in_sel});
        idle();
        Grc = 1'b1; Rout = 1'b1;
        settle("rc_out");
        sb_push("rc_outsel", 32'h10);
        sb_pop({16'd0, R_out_sel});
        idle();

        Gra = 1'b1; Rin = 1'b1; BusMuxOut = 32'h1234;
        step("wr5");
        idle();
        sb_push("r5_pre", 32'h1234);
        sb_pop(R_flat[5*32 +: 32]);
        pulse_clear("aclr");
        sb_push("aclr_r5", 32'd0);
        sb_pop(R_flat[5*32 +: 32]);

        BusMuxOut = 32'h0A9A_0000; IRin = 1'b1;
        step("irld2");
        idle();
        Grc = 1'b1; Rin = 1'b1; BusMuxOut = 32'hDEAD_BEEF;
        step("wr4");
        sb_push("r4_val", 32'hDEAD_BEEF);
        sb_pop(R_flat[4*32 +: 32]);
        Rin = 1'b0;
        settle("rin_drop");
        sb_push("insel_zero", 32'd0);
        sb_pop({16'd0, R_in_sel});
        idle();

        BusMuxOut = 32'd0; IRin = 1'b1;
        step("ir_ra0");
        idle();
        Gra = 1'b1; Rin = 1'b1; BusMuxOut = 32'h77;
        step("wr0");
        Rin = 1'b0; BAout = 1'b1;
        settle("ba0");
        sb_push("ba_r0", 32'd0);
        sb_pop(R_flat[31:0]);
        sb_push("ba_outsel", 32'h1);
        sb_pop({16'd0, R_out_sel});
        BAout = 1'b0; Rout = 1'b1;
        settle("rout0");
        sb_push("rout_r0", 32'h77);
        sb_pop(R_flat[31:0]);
        idle();

        BusMuxOut = 32'h0004_0000; IRin = 1'b1;
        step("sx_neg");
        sb_push("sx_neg_c", 32'hFFFC_0000);
        sb_pop(C_sign_extended);
        BusMuxOut = 32'h0003_FFFF;
        step("sx_pos");
        sb_push("sx_pos_c", 32'h0003_FFFF);
        sb_pop(C_sign_extended);
        idle();

        BusMuxOut = 32'h0A9A_0000; IRin = 1'b1;
        step("irld3");
        idle();
        Gra = 1'b1; Grb = 1'b1; Rin = 1'b1; BusMuxOut = 32'hA5A5_0001;
        step("conf");
        idle();
        sb_push("conf_r5", 32'hA5A5_0001);
        sb_pop(R_flat[5*32 +: 32]);
        sb_push("conf_err", 32'd1);
        sb_pop({31'd0, sel_error});
        step("err_hold1");
        step("err_hold2");
        sb_push("err_sticky", 32'd1);
        sb_pop({31'd0, sel_error});
        pulse_clear("err_clr");
        sb_push("err_cleared", 32'd0);
        sb_pop({31'd0, sel_error});

        BusMuxOut = 32'h0A9A_0000; IRin = 1'b1;
        step("irld4");
        BusMuxOut = 32'h0080_0000; Gra = 1'b1; Rin = 1'b1;
        step("ir_rin");
        sb_push("irrin_r5", 32'h0080_0000);
        sb_pop(R_flat[5*32 +: 32]);
        sb_push("irrin_r1", 32'd0);
        sb_pop(R_flat[1*32 +: 32]);
        sb_push("irrin_ir", 32'h0080_0000);
        sb_pop(IR);
        idle();
        Gra = 1'b1; Rout = 1'b1;
        settle("new_dec");
        sb_push("new_outsel", 32'h2);
        sb_pop({16'd0, R_out_sel});
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpr_select_file.md
Name: gpr_select_file

Overview:
- Bus-consumer end of the datapath bus. Latches the bus value (BusMuxOut) into the instruction register and the 16 general-purpose registers.
- Select-and-encode logic decodes IR register fields into one-hot Rin/Rout enables.
- The Rout enables and register contents drive the bus mux's R0out..R15out and BusMuxIn_R0..R15 inputs.
- Also produces C_sign_extended for the bus mux's Cout input.

Parameters:
- DATA_W, 32, bus and register width.
- NREG, 16, number of general-purpose registers; register fields are 4 bits.
- C_W, 19, width of IR constant field IR[C_W-1:0] before sign extension.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear  input  1  reset, asynchronous, active-high; forces all state to zero.
- BusMuxOut  input  DATA_W  current bus value.
- IRin  input  1  capture BusMuxOut into IR at the next edge.
- Gra  input  1  select Ra field IR[26:23].
- Grb  input  1  select Rb field IR[22:19].
- Grc  input  1  select Rc field IR[18:15].
- Rin  input  1  write the selected register from the bus.
- Rout  input  1  drive the selected register onto the bus.
- BAout  input  1  drive the selected register onto the bus, with R0 forced to zero.
- IR  output  DATA_W  instruction register contents.
- R_flat  output  NREG*DATA_W  register contents; Ri at bits [32i+31:32i]; R0 slice gated per BAout.
- R_out_sel  output  NREG  one-hot R0out..R15out to the bus mux.
- R_in_sel  output  NREG  one-hot R0in..R15in; exported for debug.
- C_sign_extended  output  DATA_W  sign-extended IR[C_W-1:0].
- sel_error  output  1  sticky flag: more than one of Gra/Grb/Grc asserted in a cycle.

Behaviour:
- Reset: clear=1 asynchronously zeroes IR, R0..R15 and sel_error. All outputs read 0 while clear is high. Reset mid-write aborts the write; the register reads 0 afterwards.
- IR: on a rising edge with IRin=1, IR <= BusMuxOut. Otherwise IR holds.
- Field select:
  - Combinational from the current registered IR.
  - Priority Gra > Grb > Grc.
  - With none asserted, no register is selected: R_in_sel = R_out_sel = 0.
- Decode:
  - idx = chosen 4-bit field; dec = one-hot(idx).
  - R_in_sel = dec when Rin, else 0.
  - R_out_sel = dec when (Rout | BAout), else 0.
- Register write: on a rising edge, Ri <= BusMuxOut for the single i with R_in_sel[i]=1. At most one register is written per cycle. R0 is writable.
- BAout gating: when BAout=1 and idx=0, the R0 slice of R_flat reads 0; the stored R0 is unchanged. Otherwise each slice equals its stored register.
- Simultaneous IRin and Rin in one cycle:
  - The register write uses the decode from the pre-edge IR.
  - IR takes the new value at the same edge.
  - Decode reflects the new IR from the next cycle.
- Read-during-write: R_flat shows the old value until the edge, then the new value. No bypass.
- C_sign_extended = {{(DATA_W-C_W){IR[C_W-1]}}, IR[C_W-1:0]}, combinational.
- sel_error:
  - Set on the rising edge when two or more of Gra/Grb/Grc are high.
  - Cleared only by clear.
  - Priority decode still applies in that cycle.
- Latency:
  - Write: one edge from Rin/IRin to visible on outputs.
  - Select outputs: zero-cycle combinational from select inputs.

Test Plan:
1. Reset: preload R5=0x1234 and IR, then pulse clear asynchronously between edges. All R_flat slices, IR, C_sign_extended and sel_error read 0 immediately, before the next edge.
2. IR load and decode:
   - BusMuxOut=0x0A9A_0000 with IRin for one edge; IR=0x0A9A0000, giving Ra=5, Rb=3, Rc=4.
   - Gra+Rout gives R_out_sel=0x0020.
   - Grb+Rin gives R_in_sel=0x0008.
   - Grc gives index 4.
3. Register write: IR as in test 2, Grc+Rin, BusMuxOut=0xDEAD_BEEF for one edge. R4 slice=0xDEADBEEF; all other slices unchanged; R_in_sel=0 once Rin drops.
4. BAout on R0:
   - Write R0=0x0000_0077 via IR with Ra=0.
   - Gra+BAout gives R0 slice=0 and R_out_sel=0x0001.
   - Gra+Rout gives R0 slice=0x77.
5. Sign extension: IR=0x0004_0000 gives C_sign_extended=0xFFFC0000. IR=0x0003_FFFF gives 0x0003FFFF.
6. Conflicts:
   - Gra+Grb+Rin asserted together: Ra register written, sel_error=1 after the edge and stays 1 until clear.
   - Separately, IRin+Rin in the same edge: the write lands at the old-IR index.
